// File: rtl/plot_framebuffer.sv
// Pixel plotter into a 160x120x3 framebuffer with 640x480 VGA scan-out (4x4 replication); PLOT_FRAMEBUFFER_CLEAR_EN adds a post-reset clear sweep.
// Latency: a pixel accepted at edge N into an empty FIFO is in RAM at N+1 and visible to scan-out from N+2.
// Backpressure: ready drops while the 8-entry FIFO is full; plots while not ready are dropped and set sticky overflow.
module plot_framebuffer (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic [2:0] colour,
   input  logic       plot,
   output logic       ready,
   output logic       overflow,
   output logic       busy,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [9:0] VGA_R,
   output logic [9:0] VGA_G,
   output logic [9:0] VGA_B
);
   localparam int unsigned NPIX = 19200;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] colour;
   } pix_t;

   pix_t        fifo_mem [0:7];
   logic [2:0]  wr_ptr;
   logic [2:0]  rd_ptr;
   logic [3:0]  count;
   logic        push;
   logic        pop;
   logic        run;
   pix_t        head;
   logic        pix_ok;
   logic [14:0] pix_addr;
   logic        clr_we;
   logic [14:0] clr_addr;
   logic        we;
   logic [14:0] waddr;
   logic [2:0]  wdat;

   // ready is forced high while reset is held so upstream never sees a stale full
   assign ready = !rst || !count[3];
   assign push  = rst && plot && !count[3];
   assign pop   = rst && run && (count != 4'd0);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{x: x, y: y, colour: colour};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 3'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 3'd1;
         end
         count <= count + {3'd0, push} - {3'd0, pop};
         if (plot && count[3]) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
   typedef enum logic {CLEAR, RUN} state_t;
   state_t state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else if (state == CLEAR) begin
         if (clr_addr == 15'(NPIX - 1)) begin
            state <= RUN;
         end
         clr_addr <= clr_addr + 15'd1;
      end
   end

   assign run    = (state == RUN);
   assign clr_we = rst && (state == CLEAR);
   assign busy   = clr_we;
`else
   assign run      = 1'b1;
   assign clr_we   = 1'b0;
   assign clr_addr = '0;
   assign busy     = 1'b0;
`endif

   // y*160 + x as shift-adds; out-of-range pixels are silently discarded on pop
   assign head     = fifo_mem[rd_ptr];
   assign pix_ok   = (head.x < 8'd160) && (head.y < 8'd120);
   assign pix_addr = ({7'd0, head.y} << 7) + ({7'd0, head.y} << 5) + {7'd0, head.x};

   always_comb begin
      we    = 1'b0;
      waddr = pix_addr;
      wdat  = head.colour;
      if (clr_we) begin
         we    = 1'b1;
         waddr = clr_addr;
         wdat  = 3'b000;
      end else if (pop && pix_ok) begin
         we = 1'b1;
      end
   end

   logic        pe;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        vis;
   logic [14:0] raddr;
   logic [2:0]  rd_dat;
   logic [2:0]  ram [0:NPIX-1];

   assign vis   = (h_cnt < 10'd640) && (v_cnt < 10'd480);
   assign raddr = ({7'd0, v_cnt[9:2]} << 7) + ({7'd0, v_cnt[9:2]} << 5) + {7'd0, h_cnt[9:2]};

   // read only inside the visible window so the address never leaves the array
   always_ff @(posedge clk) begin
      if (we) begin
         ram[waddr] <= wdat;
      end
      if (pe && vis) begin
         rd_dat <= ram[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pe          <= 1'b1;
         VGA_CLK     <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
      end else begin
         pe      <= !pe;
         VGA_CLK <= pe;
         if (pe) begin
            VGA_HS      <= !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
            VGA_VS      <= !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
            VGA_BLANK_N <= vis;
            if (h_cnt == 10'd799) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end
      end
   end

   assign VGA_SYNC_N = 1'b0;
   assign VGA_R      = (VGA_BLANK_N && rd_dat[2]) ? 10'h3FF : 10'h000;
   assign VGA_G      = (VGA_BLANK_N && rd_dat[1]) ? 10'h3FF : 10'h000;
   assign VGA_B      = (VGA_BLANK_N && rd_dat[0]) ? 10'h3FF : 10'h000;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Bench for plot_framebuffer: reference model of FIFO, framebuffer and VGA raster driven from pixel-index arithmetic.
`timescale 1ns/1ps
module tb_plot_framebuffer;
   localparam int NPIX = 19200;
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       ready, overflow, busy;
   logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic [9:0] VGA_R, VGA_G, VGA_B;

   always #10 clk = ~clk;

   plot_framebuffer dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .colour(colour), .plot(plot),
      .ready(ready), .overflow(overflow), .busy(busy),
      .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [2:0]  m_ram [NPIX];
   bit          m_known [NPIX];
   logic [18:0] mq [$];
   bit          m_ovf;
   int          clr_left;
   longint      k;
   bit          e_vclk, e_hs, e_vs, e_blank, e_known;
   logic [2:0]  e_rgb;
   int          step_bad, vga_bad, busy_seen;
   string       step_msg, vga_msg;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] c;
      int         chk_addr;
      logic [2:0] chk_val;
   } vec_t;
   vec_t tbl [9];

   int   f1, f2, r1;
   logic prev_hs;

   task automatic check(string name, longint act, longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic note_step(string m);
      if (step_bad == 0) step_msg = m;
      step_bad++;
   endtask

   task automatic note_vga(string m);
      if (vga_bad == 0) vga_msg = m;
      vga_bad++;
   endtask

   task automatic check_steps(string name);
      tests++;
      if (step_bad != 0) begin
         fails++;
         $display("FAIL %s: %0d cycle mismatches, first: %s", name, step_bad, step_msg);
      end
      step_bad = 0;
   endtask

   task automatic check_vga(string name);
      tests++;
      if (vga_bad != 0) begin
         fails++;
         $display("FAIL %s: %0d cycle mismatches, first: %s", name, vga_bad, vga_msg);
      end
      vga_bad = 0;
   endtask

   task automatic check_ram(string name);
      int bad = 0;
      int first = 0;
      for (int i = 0; i < NPIX; i++) begin
         if (m_known[i] && dut.ram[i] !== m_ram[i]) begin
            if (bad == 0) first = i;
            bad++;
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s: %0d entries differ, first addr %0d got %0d expected %0d",
                  name, bad, first, dut.ram[first], m_ram[first]);
      end
   endtask

   task automatic check_reset_outputs(string t);
      check({t, "_ready"}, ready, 1);
      check({t, "_overflow"}, overflow, 0);
      check({t, "_busy"}, busy, 0);
      check({t, "_vga_clk"}, VGA_CLK, 0);
      check({t, "_hs"}, VGA_HS, 1);
      check({t, "_vs"}, VGA_VS, 1);
      check({t, "_blank_n"}, VGA_BLANK_N, 0);
      check({t, "_rgb"}, VGA_R | VGA_G | VGA_B, 0);
      check({t, "_sync_n"}, VGA_SYNC_N, 0);
   endtask

   // one clock: pre-edge handshake check, model update at the edge, post-edge output check
   task automatic step();
      bit          rdy_e, busy_e;
      int          pre, wa, h, v, ra;
      longint      p;
      logic [18:0] e;
      logic [9:0]  xr, xg, xb;
      #1;
      rdy_e = !rst || (mq.size() < 8);
      busy_e = rst && (clr_left > 0);
      if (ready !== rdy_e || busy !== busy_e)
         note_step($sformatf("k=%0d ready %b want %b busy %b want %b", k, ready, rdy_e, busy, busy_e));
      busy_seen += int'(busy);
      @(posedge clk);
      wa = -1;
      if (!rst) begin
         mq.delete();
         m_ovf = 0;
         clr_left = CLR ? NPIX : 0;
         k = 0;
         e_vclk = 0; e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = 0; e_known = 1;
      end else begin
         k++;
         e_vclk = k[0];
         if (k[0]) begin
            p = ((k - 1) / 2) % 420000;
            h = int'(p % 800);
            v = int'(p / 800);
            e_hs = !(h >= 656 && h <= 751);
            e_vs = !(v >= 490 && v <= 491);
            e_blank = (h < 640) && (v < 480);
            if (e_blank) begin
               ra = (v / 4) * 160 + h / 4;
               e_rgb = m_ram[ra];
               e_known = m_known[ra];
            end
         end
         pre = mq.size();
         if (clr_left > 0) begin
            wa = NPIX - clr_left;
            m_ram[wa] = 3'b000;
            m_known[wa] = 1;
            clr_left--;
         end else if (pre > 0) begin
            e = mq.pop_front();
            if (e[18:11] < 160 && e[10:3] < 120) begin
               wa = int'(e[10:3]) * 160 + int'(e[18:11]);
               m_ram[wa] = e[2:0];
               m_known[wa] = 1;
            end
         end
         if (plot) begin
            if (pre < 8) mq.push_back({x, y, colour});
            else m_ovf = 1;
         end
      end
      #1;
      if (overflow !== m_ovf)
         note_step($sformatf("k=%0d overflow %b want %b", k, overflow, m_ovf));
      if (wa >= 0 && dut.ram[wa] !== m_ram[wa])
         note_step($sformatf("k=%0d ram[%0d] %0d want %0d", k, wa, dut.ram[wa], m_ram[wa]));
      if (VGA_CLK !== e_vclk || VGA_HS !== e_hs || VGA_VS !== e_vs ||
          VGA_BLANK_N !== e_blank || VGA_SYNC_N !== 1'b0)
         note_vga($sformatf("k=%0d clk/hs/vs/blank/sync %b%b%b%b%b want %b%b%b%b0", k,
                  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, e_vclk, e_hs, e_vs, e_blank));
      xr = (e_blank && e_rgb[2]) ? 10'h3FF : 10'h000;
      xg = (e_blank && e_rgb[1]) ? 10'h3FF : 10'h000;
      xb = (e_blank && e_rgb[0]) ? 10'h3FF : 10'h000;
      if ((!e_blank || e_known) && (VGA_R !== xr || VGA_G !== xg || VGA_B !== xb))
         note_vga($sformatf("k=%0d rgb %h/%h/%h want %h/%h/%h", k, VGA_R, VGA_G, VGA_B, xr, xg, xb));
   endtask

   task automatic plot_one(logic [7:0] px, logic [7:0] py, logic [2:0] pc);
      x = px; y = py; colour = pc; plot = 1'b1;
      step();
      plot = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NPIX; i++) begin
         m_known[i] = 0;
         m_ram[i] = 3'b000;
      end
      clr_left = 0; k = 0; m_ovf = 0;
      step_bad = 0; vga_bad = 0; busy_seen = 0;
      rst = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;

      tbl[0] = '{8'd10,  8'd52,  3'd1, 8330,  3'd1};
      tbl[1] = '{8'd0,   8'd0,   3'd4, 0,     3'd4};
      tbl[2] = '{8'd159, 8'd119, 3'd7, 19199, 3'd7};
      tbl[3] = '{8'd159, 8'd0,   3'd2, 159,   3'd2};
      tbl[4] = '{8'd0,   8'd119, 3'd5, 19040, 3'd5};
      tbl[5] = '{8'd0,   8'd1,   3'd6, 160,   3'd6};
      tbl[6] = '{8'd160, 8'd0,   3'd3, 160,   3'd6};
      tbl[7] = '{8'd0,   8'd120, 3'd3, 19040, 3'd5};
      tbl[8] = '{8'd255, 8'd255, 3'd0, 19199, 3'd7};

      // reset state
      repeat (3) step();
      check_reset_outputs("reset");

      // plot held high across 12 cycles straight out of reset
      busy_seen = 0;
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         x = 8'(i); y = 8'd5; colour = 3'(i % 7 + 1); plot = 1'b1;
         step();
      end
      plot = 1'b0;
      check("hold_overflow", overflow, CLR);
      check("hold_ready", ready, !CLR);
      check("hold_busy", busy, CLR);
      for (int i = 0; i < 20000 && busy; i++) step();
      check("busy_cycles", busy_seen, CLR ? NPIX : 0);
      repeat (10) step();
      for (int i = 0; i < 12; i++)
         check($sformatf("hold_px%0d", i), dut.ram[800 + i], (CLR && i >= 8) ? 0 : (i % 7 + 1));
      check_steps("hold_cycles");

      // first-write latency: old value one edge after accept, new value the edge after
      plot_one(8'd10, 8'd52, 3'd0);
      repeat (2) step();
      plot_one(8'd10, 8'd52, 3'd1);
      check("lat_edge_n", dut.ram[8330], 0);
      step();
      check("lat_edge_n1", dut.ram[8330], 1);
      check("lat_overflow", overflow, m_ovf);

      // single-pixel table including range boundaries and discarded coordinates
      for (int i = 0; i < 9; i++) begin
         plot_one(tbl[i].x, tbl[i].y, tbl[i].c);
         repeat (2) step();
         check($sformatf("tbl%0d_ram", i), dut.ram[tbl[i].chk_addr], tbl[i].chk_val);
         check($sformatf("tbl%0d_ready", i), ready, 1);
         check($sformatf("tbl%0d_overflow", i), overflow, m_ovf);
      end
      check_ram("tbl_ram");
      check_steps("tbl_cycles");

      // random bursts with some out-of-range coordinates
      for (int i = 0; i < 400; i++) begin
         plot = ($urandom_range(0, 3) != 0);
         x = 8'($urandom_range(0, 175));
         y = 8'($urandom_range(0, 130));
         colour = 3'($urandom_range(0, 7));
         step();
      end
      plot = 1'b0;
      repeat (10) step();
      check_ram("rand_ram");
      check_steps("rand_cycles");

      // scan-out after a mid-frame reset
      plot_one(8'd0, 8'd0, 3'b100);
      plot_one(8'd1, 8'd0, 3'b001);
      plot_one(8'd0, 8'd1, 3'b010);
      repeat (3) step();
      rst = 1'b0;
      step();
      check_reset_outputs("midframe");
      rst = 1'b1;
      f1 = -1; f2 = -1; r1 = -1; prev_hs = 1'b1;
      for (int i = 0; i < 12800; i++) begin
         step();
         if (prev_hs && !VGA_HS) begin
            if (f1 < 0) f1 = int'(k);
            else if (f2 < 0) f2 = int'(k);
         end
         if (!prev_hs && VGA_HS && r1 < 0) r1 = int'(k);
         prev_hs = VGA_HS;
         if (k == 1401) begin
            check("blank_h700", VGA_BLANK_N, 0);
            check("blank_rgb", VGA_R | VGA_G | VGA_B, 0);
         end
`ifndef PLOT_FRAMEBUFFER_CLEAR_EN
         if (k == 1 || k == 7 || k == 4807) begin
            check($sformatf("red_k%0d", k), VGA_R, 10'h3FF);
            check($sformatf("red_gb_k%0d", k), VGA_G | VGA_B, 0);
         end
         if (k == 9) check("blue_h4", VGA_B, 10'h3FF);
         if (k == 6401) check("green_v4", VGA_G, 10'h3FF);
`endif
      end
      check("hs_period", f2 - f1, 1600);
      check("hs_low", r1 - f1, 192);
      check_ram("final_ram");
      check_steps("final_cycles");
      check_vga("vga_raster");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/plot_framebuffer.md
PLOT_FRAMEBUFFER -- requirements
Module: plot_framebuffer

Interface
REQ-001 clk  input  1  system clock, 50 MHz.
REQ-002 rst  input  1  synchronous reset, active-low; sampled on rising clk edge.
REQ-003 x  input  8  pixel column; valid 0..159.
REQ-004 y  input  8  pixel row; valid 0..119.
REQ-005 colour  input  3  {R,G,B}, 1 bit per channel.
REQ-006 plot  input  1  write request; sampled every clk.
REQ-007 ready  output  1  high when the write FIFO can accept a pixel.
REQ-008 overflow  output  1  sticky; a plot arrived while ready was low.
REQ-009 busy  output  1  framebuffer clear sweep in progress.
REQ-010 VGA_CLK  output  1  25 MHz pixel clock (clk/2).
REQ-011 VGA_HS, VGA_VS  output  1 each  active-low syncs.
REQ-012 VGA_BLANK_N  output  1  high during visible area.
REQ-013 VGA_SYNC_N  output  1  constant 0.
REQ-014 VGA_R, VGA_G, VGA_B  output  10 each  colour channels.

Function
REQ-015 Write accept: plot && ready at an edge pushes {x,y,colour} into an 8-entry FIFO.
REQ-016 plot && !ready: pixel dropped, overflow set to 1 until reset.
REQ-017 ready = (FIFO count < 8) ; push and pop in the same cycle leave count unchanged.
REQ-018 Drain: state RUN and FIFO non-empty -> pop one entry per clk; no pop in CLEAR.
REQ-019 Popped entry with x>=160 or y>=120: discarded, no RAM write, no error flag.
REQ-020 In-range entry: RAM[y*160+x] <= colour; address via (y<<7)+(y<<5)+x, 15 bits.
REQ-021 Latency: pixel accepted at edge N into an empty FIFO is written to RAM at edge N+1; readable by scan-out from edge N+2.
REQ-022 RAM: 19200 x 3 bits, one write port, one registered read port.
REQ-023 Pixel enable pe toggles every clk, 1 after reset; VGA_CLK = registered pe; H/V counters advance only when pe=1.
REQ-024 H counter 0..799 wraps to 0; V counter 0..524, increments on H wrap, wraps to 0.
REQ-025 Visible: h<640 && v<480; HS low for h 656..751; VS low for v 490..491.
REQ-026 Read address = (v>>2)*160 + (h>>2); 4x4 pixel replication.
REQ-027 HS, VS, BLANK_N delayed one pe-cycle to align with RAM read data.
REQ-028 Each channel bit expands to 10'h3FF (1) or 10'h000 (0); all zero when BLANK_N=0.
REQ-029 Same-address write and read in one cycle: read returns old data.
REQ-030 States: CLEAR (sweep) -> RUN after last address; RUN holds until reset.

Reset
REQ-031 rst=0: FIFO count 0, overflow 0, H=V=0, pe 1, VGA_CLK 0, HS 1, VS 1, BLANK_N 0, RGB 0.
REQ-032 ready=1 and busy=0 during reset; reset mid-sweep restarts sweep at address 0.
REQ-033 FIFO contents lost on reset; pending pixels never written.

Configuration
REQ-034 Macro PLOT_FRAMEBUFFER_CLEAR_EN defined: after reset enter CLEAR, write 3'b000 to addresses 0..19199 one per clk, busy=1 throughout, then RUN (19200 cycles).
REQ-035 Without it: reset enters RUN directly, busy tied 0, RAM contents preserved across reset.
REQ-036 Pushes during CLEAR accepted until FIFO full, drained in order after CLEAR.

Verification
REQ-037 Reset, plot x=10 y=52 colour=3'b001 one cycle -> RAM[8330]=3'b001 two edges later; overflow=0.
REQ-038 plot x=160 y=0 then x=0 y=120 -> no RAM change, ready stays 1, overflow 0.
REQ-039 CLEAR_EN: plot held high 12 cycles after reset -> ready low after 8 accepts, overflow=1, busy high 19200 cycles, first 8 pixels written after.
REQ-040 Run 2 frames -> HS period 1600 clk, HS low 192 clk, VS low 3200 clk, frame 840000 clk.
REQ-041 RAM[0]=3'b100 -> VGA_R=10'h3FF, G=B=0 for first 4 visible pixels of lines 0..3; RGB=0 while BLANK_N=0.
REQ-042 Assert rst mid-frame -> all outputs at REQ-031 values next edge; counters restart at 0.
